// File: rtl/drum_pkg.sv
// drum_pkg: shared sizes and sequencer state type
// for the drum machine pattern logic.
package drum_pkg;

   localparam int NUM_TRACKS_DEF = 4;
   localparam int NUM_STEPS_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      PLAY  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/step_sequencer_tick_detect.sv
// tick_detect: turns the tempo counter's beat count
// into a one-cycle tick on each nonzero change.
module tick_detect (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [31:0] tick_count,
   output logic        tick
);

   logic [31:0] prev_count;

   // remember last seen count every cycle
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         prev_count <= '0;
      else
         prev_count <= tick_count;
   end

   // a counter reset to zero is never a tick
   assign tick = (tick_count != prev_count) &&
                 (tick_count != 32'd0);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: steps through the pattern grid
// on each tempo tick and fires per-track triggers.
module step_sequencer
   import drum_pkg::*;
#(
   parameter  int NUM_TRACKS = NUM_TRACKS_DEF,
   parameter  int NUM_STEPS  = NUM_STEPS_DEF,
   localparam int STEP_W     = $clog2(NUM_STEPS),
   localparam int TRACK_W    =
      (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [31:0]           tick_count,
   input  logic                  run,
   input  logic [NUM_TRACKS-1:0] mute,
   input  logic                  edit_we,
   input  logic [TRACK_W-1:0]    edit_track,
   input  logic [STEP_W-1:0]     edit_step,
   input  logic                  edit_val,
   input  logic                  pattern_clear,
   output logic [NUM_TRACKS-1:0] trig,
   output logic                  step_strobe,
   output logic [STEP_W-1:0]     step_idx,
   output logic                  bar_done,
   output logic                  playing
);

   seq_state_t state;

   logic tick;

   logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern;

   logic [STEP_W-1:0]     fire_idx;
   logic [NUM_TRACKS-1:0] fire_col;
   logic                  track_ok;

   tick_detect u_tick (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .tick_count (tick_count),
      .tick       (tick)
   );

   assign track_ok = (32'(edit_track) < NUM_TRACKS);

   // index about to fire and its grid column
   always_comb begin
      fire_idx = '0;
      fire_col = '0;
      if (state == PLAY)
         fire_idx = step_idx + STEP_W'(1);
      for (int t = 0; t < NUM_TRACKS; t++)
         fire_col[t] = pattern[t][fire_idx];
   end

   // pattern grid; fire reads the pre-edit value
   always_ff @(posedge CLOCK_50) begin
      if (reset || pattern_clear)
         pattern <= '0;
      else if (edit_we && track_ok)
         pattern[edit_track][edit_step] <= edit_val;
   end

   // play state machine with registered outputs
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         trig        <= '0;
         step_strobe <= 1'b0;
         bar_done    <= 1'b0;
         step_idx    <= '0;
         playing     <= 1'b0;
      end else begin
         trig        <= '0;
         step_strobe <= 1'b0;
         bar_done    <= 1'b0;
         if (!run) begin
            state    <= IDLE;
            step_idx <= '0;
            playing  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state   <= ARMED;
                  playing <= 1'b1;
               end
               ARMED: begin
                  if (tick) begin
                     state       <= PLAY;
                     step_idx    <= '0;
                     trig        <= fire_col & ~mute;
                     step_strobe <= 1'b1;
                  end
               end
               PLAY: begin
                  if (tick) begin
                     step_idx    <= fire_idx;
                     trig        <= fire_col & ~mute;
                     step_strobe <= 1'b1;
                     bar_done    <= (fire_idx == '0);
                  end
               end
               default: begin
                  state   <= IDLE;
                  playing <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of stepping,
// muting, stop/restart, counter reset and editing.
module tb_step_sequencer;

   logic        CLOCK_50;
   logic        reset;
   logic [31:0] tick_count;
   logic        run;
   logic [3:0]  mute;
   logic        edit_we;
   logic [1:0]  edit_track;
   logic [3:0]  edit_step;
   logic        edit_val;
   logic        pattern_clear;
   logic [3:0]  trig;
   logic        step_strobe;
   logic [3:0]  step_idx;
   logic        bar_done;
   logic        playing;

   int checks;
   int errors;

   step_sequencer dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .tick_count    (tick_count),
      .run           (run),
      .mute          (mute),
      .edit_we       (edit_we),
      .edit_track    (edit_track),
      .edit_step     (edit_step),
      .edit_val      (edit_val),
      .pattern_clear (pattern_clear),
      .trig          (trig),
      .step_strobe   (step_strobe),
      .step_idx      (step_idx),
      .bar_done      (bar_done),
      .playing       (playing)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic tick(input logic [31:0] v);
      tick_count = v;
      cyc(1);
   endtask

   task automatic wr(input logic [1:0] t,
                     input logic [3:0] s,
                     input logic v);
      edit_we    = 1'b1;
      edit_track = t;
      edit_step  = s;
      edit_val   = v;
      cyc(1);
      edit_we    = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      tick_count    = 32'd0;
      run           = 1'b0;
      mute          = 4'b0000;
      edit_we       = 1'b0;
      edit_track    = 2'd0;
      edit_step     = 4'd0;
      edit_val      = 1'b0;
      pattern_clear = 1'b0;
      cyc(3);
      chk("rst_trig",    trig,        4'b0000);
      chk("rst_strobe",  step_strobe, 1'b0);
      chk("rst_idx",     step_idx,    4'd0);
      chk("rst_bar",     bar_done,    1'b0);
      chk("rst_playing", playing,     1'b0);
      reset = 1'b0;
      cyc(1);

      // test 1: track0 on steps 0,4,8,12
      wr(2'd0, 4'd0, 1'b1);
      wr(2'd0, 4'd4, 1'b1);
      wr(2'd0, 4'd8, 1'b1);
      wr(2'd0, 4'd12, 1'b1);
      chk("idle_playing", playing, 1'b0);
      run = 1'b1;
      cyc(1);
      chk("armed_playing", playing, 1'b1);
      chk("armed_strobe", step_strobe, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         tick(k);
         chk("t1_strobe", step_strobe, 1'b1);
         chk("t1_idx", step_idx, 32'(k - 1));
         chk("t1_trig", trig,
             ((k - 1) % 4 == 0) ? 4'b0001 : 4'b0000);
         chk("t1_bar", bar_done, 1'b0);
         cyc(1);
         chk("t1_pulse", step_strobe, 1'b0);
         chk("t1_trig_off", trig, 4'b0000);
         cyc(8);
      end

      // test 2: wrap to step 0
      tick(17);
      chk("t2_idx", step_idx, 4'd0);
      chk("t2_bar", bar_done, 1'b1);
      chk("t2_trig", trig, 4'b0001);
      cyc(1);
      chk("t2_bar_off", bar_done, 1'b0);

      // test 3: mute track0 at step 4
      wr(2'd1, 4'd4, 1'b1);
      tick(18);
      tick(19);
      tick(20);
      chk("t3_idx3", step_idx, 4'd3);
      mute = 4'b0001;
      tick(21);
      chk("t3_idx", step_idx, 4'd4);
      chk("t3_trig", trig, 4'b0010);
      mute = 4'b0000;

      // test 4: stop beats tick, restart at 0
      cyc(2);
      tick(22);
      chk("t4_idx5", step_idx, 4'd5);
      run = 1'b0;
      tick(23);
      chk("t4_trig", trig, 4'b0000);
      chk("t4_strobe", step_strobe, 1'b0);
      chk("t4_idx", step_idx, 4'd0);
      chk("t4_playing", playing, 1'b0);
      cyc(2);
      run = 1'b1;
      cyc(1);
      chk("t4_rearm", playing, 1'b1);
      tick(24);
      chk("t4_r_idx", step_idx, 4'd0);
      chk("t4_r_trig", trig, 4'b0001);
      chk("t4_r_bar", bar_done, 1'b0);
      cyc(2);
      tick(25);
      chk("t4_play_idx", step_idx, 4'd1);

      // test 5: counter reset is not a tick
      cyc(2);
      tick(0);
      chk("t5_strobe", step_strobe, 1'b0);
      chk("t5_idx", step_idx, 4'd1);
      cyc(2);
      tick(1);
      chk("t5_adv_strobe", step_strobe, 1'b1);
      chk("t5_adv_idx", step_idx, 4'd2);

      // test 6: edit during fire uses old value
      cyc(2);
      edit_we    = 1'b1;
      edit_track = 2'd2;
      edit_step  = 4'd3;
      edit_val   = 1'b1;
      tick(2);
      edit_we = 1'b0;
      chk("t6_idx", step_idx, 4'd3);
      chk("t6_old", trig, 4'b0000);
      for (int k = 3; k <= 17; k++) begin
         cyc(1);
         tick(k);
      end
      chk("t6_idx2", step_idx, 4'd2);
      cyc(1);
      tick(18);
      chk("t6_new", trig, 4'b0100);
      cyc(1);
      tick(50);
      chk("t6_jump_idx", step_idx, 4'd4);
      chk("t6_jump_trig", trig, 4'b0011);
      edit_we       = 1'b1;
      edit_track    = 2'd3;
      edit_step     = 4'd0;
      edit_val      = 1'b1;
      pattern_clear = 1'b1;
      cyc(1);
      edit_we       = 1'b0;
      pattern_clear = 1'b0;
      for (int k = 51; k <= 62; k++) begin
         cyc(1);
         tick(k);
         chk("t6_clr_trig", trig, 4'b0000);
      end
      chk("t6_wrap_idx", step_idx, 4'd0);
      chk("t6_wrap_bar", bar_done, 1'b1);

      // reset mid-play with a simultaneous tick
      wr(2'd0, 4'd1, 1'b1);
      reset = 1'b1;
      tick(63);
      chk("rp_trig", trig, 4'b0000);
      chk("rp_strobe", step_strobe, 1'b0);
      chk("rp_idx", step_idx, 4'd0);
      chk("rp_playing", playing, 1'b0);
      reset = 1'b0;
      cyc(2);
      tick(64);
      chk("rp_clr_trig", trig, 4'b0000);
      chk("rp_clr_strobe", step_strobe, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Downstream consumer of the tempo counter in the drum machine.
- Watches the counter's 32-bit beat count. On each increment it advances a step index and fires one-cycle trigger pulses for every drum track whose pattern bit is set at that step.
- Holds the editable pattern grid. Its trigger outputs feed the per-track sample players.

Parameters:
- NUM_TRACKS, 4, number of drum tracks (rows of pattern grid)
- NUM_STEPS, 16, steps per bar (columns); must be a power of two, at least 2
- STEP_W, $clog2(NUM_STEPS), step index width
- TRACK_W, $clog2(NUM_TRACKS) (minimum 1), track select width

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_count  in  32  beat count from the tempo counter; each increment is one step tick
- run  in  1  level; 1 = play, 0 = stop
- mute  in  NUM_TRACKS  per-track trigger mask; 1 = muted
- edit_we  in  1  pattern write strobe
- edit_track  in  TRACK_W  track to write
- edit_step  in  STEP_W  step to write
- edit_val  in  1  bit value to write
- pattern_clear  in  1  clears the entire grid
- trig  out  NUM_TRACKS  one-cycle trigger pulses
- step_strobe  out  1  one-cycle pulse on each fired step
- step_idx  out  STEP_W  index of the most recently fired step
- bar_done  out  1  one-cycle pulse when a step fires at index 0 after wrapping from NUM_STEPS-1
- playing  out  1  high in ARMED and PLAY states

Behaviour:
- Reset values (synchronous, active-high, on CLOCK_50):
  - state = IDLE
  - trig = 0, step_strobe = 0, bar_done = 0, step_idx = 0, playing = 0
  - prev_count = 0
  - all pattern bits = 0
- Tick detection:
  - prev_count <= tick_count every cycle, including in IDLE.
  - tick = (tick_count != prev_count) && (tick_count != 0).
  - The zero exclusion means a counter reset never produces a tick.
  - A jump of more than +1 still counts as exactly one tick.
- Latency: tick_count first differs at edge N; trig, step_strobe and step_idx update at edge N+1. Pulses last exactly one cycle.
- State machine (seq_state_t: IDLE, ARMED, PLAY):
  - IDLE: outputs quiescent. run=1 -> ARMED next cycle.
  - ARMED: playing=1. On tick, fire step 0 (step_idx stays 0, bar_done=0) -> PLAY.
  - PLAY: on tick, step_idx <= (step_idx+1) mod NUM_STEPS and fire the new index. bar_done=1 when the new index is 0.
  - Any state with run=0 -> IDLE next cycle: step_idx <= 0, trig=0, step_strobe=0. Stop beats a simultaneous tick.
  - run toggling 1->0->1 always restarts from step 0 via ARMED.
- Fire:
  - trig[t] = pattern[t][idx] & ~mute[t], registered.
  - step_strobe = 1 even if trig is all zeros.
- Pattern grid: NUM_TRACKS x NUM_STEPS flops.
  - pattern_clear=1: all bits <= 0 next edge; takes priority over edit_we.
  - edit_we=1: pattern[edit_track][edit_step] <= edit_val.
  - edit_track >= NUM_TRACKS: write ignored.
  - A write to the column being fired in the same cycle: the fire uses the old value (read-before-write); the new value is used from the next tick.
  - Edits are allowed in every state.
- mute is sampled in the fire cycle only; it is not latched.
- Reset mid-play: next edge is the full reset state. The grid is cleared and no trigger is emitted.
- Arithmetic: step wrap uses natural STEP_W overflow. No 32-bit arithmetic beyond the equality compare.

Decomposition:
- Package drum_pkg holds:
  - NUM_TRACKS_DEF, NUM_STEPS_DEF
  - seq_state_t enum (IDLE, ARMED, PLAY)
- Sub-module tick_detect:
  - Ports: CLOCK_50, reset, tick_count[31:0], tick.
  - Contains prev_count and the nonzero-change compare.
  - Shared with any other block that consumes the tempo counter.

Test Plan:
1. Reset, then program track0 steps {0,4,8,12}=1; run=1; increment tick_count 1..16 every 10 cycles -> trig[0] pulses at steps 0,4,8,12 only; step_idx goes 0..15; bar_done is 0 throughout.
2. Continue to tick 17 -> step_idx=0, bar_done=1 for one cycle, trig[0]=1.
3. mute=4'b0001 during step 4 with track0 and track1 both set at step 4 -> trig=4'b0010.
4. run=0 in the same cycle tick_count increments at step_idx=5 -> no trig; step_idx=0, playing=0. run=1 with next tick -> step 0 fires, state PLAY.
5. tick_count drops to 0 (counter reset) while PLAY -> no tick or step advance. A later change to 1 -> advance by one step.
6. edit_we writes track2 step 3 = 1 in the same cycle step 3 fires (old 0) -> trig[2]=0 now, =1 next bar. pattern_clear with edit_we together -> grid all zero.
